// File: rtl/nr_div_pipe_ctl.sv
// Sign-magnitude fixed-point divider, iterative non-restoring, one quotient bit per clock.
// Start/done handshake with operand latching, divide-by-zero and overflow saturation.
//
// state | meaning
// IDLE  | ready for a new operation; holds last result
// RUN   | one non-restoring iteration per clock
// FIX   | saturate / sign-fix, register outputs, pulse done
module nr_div_pipe_ctl #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] numerator,
    input  logic [WIDTH-1:0] denominator,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic             dbz,
    output logic             ovf
);

    localparam int ITER = WIDTH - 1 + FRAC;
    localparam int MAG  = WIDTH - 1;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [MAG-1:0] MAXMAG = {MAG{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_nxt;
    logic [ITER-1:0]  q_reg, q_nxt;
    logic [WIDTH:0]   a_reg, a_nxt;
    logic [MAG-1:0]   m_reg, m_nxt;
    logic             sign_reg, sign_nxt;
    logic             dbz_pend, dbz_pend_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             done_nxt, dbz_nxt, ovf_nxt;
    logic [WIDTH-1:0] quotient_nxt;

    logic [WIDTH:0]   a_sh, a_new, m_ext;
    logic [ITER-1:0]  q_hi;
    logic [MAG-1:0]   res_mag;

    // Non-restoring step: add back when the remainder went negative, otherwise subtract.
    assign a_sh    = {a_reg[WIDTH-1:0], q_reg[ITER-1]};
    assign m_ext   = {2'b00, m_reg};
    assign a_new   = a_reg[WIDTH] ? (a_sh + m_ext) : (a_sh - m_ext);
    assign q_hi    = q_reg >> MAG;
    assign res_mag = q_reg[MAG-1:0];
    assign ready   = (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            q_reg    <= '0;
            a_reg    <= '0;
            m_reg    <= '0;
            sign_reg <= 1'b0;
            dbz_pend <= 1'b0;
            cnt      <= '0;
            done     <= 1'b0;
            quotient <= '0;
            dbz      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_nxt;
            q_reg    <= q_nxt;
            a_reg    <= a_nxt;
            m_reg    <= m_nxt;
            sign_reg <= sign_nxt;
            dbz_pend <= dbz_pend_nxt;
            cnt      <= cnt_nxt;
            done     <= done_nxt;
            quotient <= quotient_nxt;
            dbz      <= dbz_nxt;
            ovf      <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        q_nxt        = q_reg;
        a_nxt        = a_reg;
        m_nxt        = m_reg;
        sign_nxt     = sign_reg;
        dbz_pend_nxt = dbz_pend;
        cnt_nxt      = cnt;
        done_nxt     = 1'b0;
        quotient_nxt = quotient;
        dbz_nxt      = dbz;
        ovf_nxt      = ovf;
        case (state)
            IDLE: begin
                if (start) begin
                    sign_nxt = numerator[WIDTH-1] ^ denominator[WIDTH-1];
                    m_nxt    = denominator[MAG-1:0];
                    q_nxt    = ITER'(numerator[MAG-1:0]) << FRAC;
                    a_nxt    = '0;
                    cnt_nxt  = CW'(ITER);
                    if (denominator[MAG-1:0] == '0) begin
                        dbz_pend_nxt = 1'b1;
                        state_nxt    = FIX;
                    end else begin
                        dbz_pend_nxt = 1'b0;
                        state_nxt    = RUN;
                    end
                end
            end
            RUN: begin
                a_nxt   = a_new;
                q_nxt   = {q_reg[ITER-2:0], ~a_new[WIDTH]};
                cnt_nxt = cnt - 1'b1;
                if (cnt == CW'(1)) state_nxt = FIX;
            end
            FIX: begin
                if (dbz_pend) begin
                    quotient_nxt = {sign_reg, MAXMAG};
                    dbz_nxt      = 1'b1;
                    ovf_nxt      = 1'b0;
                end else if (|q_hi) begin
                    quotient_nxt = {sign_reg, MAXMAG};
                    dbz_nxt      = 1'b0;
                    ovf_nxt      = 1'b1;
                end else begin
                    // A zero magnitude never carries a negative sign.
                    quotient_nxt = {sign_reg & (|res_mag), res_mag};
                    dbz_nxt      = 1'b0;
                    ovf_nxt      = 1'b0;
                end
                dbz_pend_nxt = 1'b0;
                done_nxt     = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
